// File: rtl/cam_fb_writer_pkg.sv
// Shared frame-buffer geometry, capture FSM encoding, write payload and pixel conversion.
package cam_fb_writer_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned FB_DATA_W = 12;
  localparam int unsigned FB_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CAM_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ARMED   = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  // Truncate each RGB565 field to its top 4 bits: {R[3:0],G[3:0],B[3:0]}.
  function automatic logic [FB_DATA_W-1:0] rgb565_to_444(input logic [15:0] pix);
    return {4'(pix[15:11] >> 1), 4'(pix[10:5] >> 2), 4'(pix[4:0] >> 1)};
  endfunction

endpackage

// File: rtl/cam_fb_writer_if.sv
// Camera input bus plus frame-buffer write port. The writer uses 'master';
// the camera/memory environment uses 'slave'.
interface cam_fb_writer_if;
  import cam_fb_writer_pkg::*;

  logic                 cam_pclk;
  logic                 cam_vsync;
  logic                 cam_href;
  logic [CAM_W-1:0]     cam_data;
  logic                 Mem_Write;
  logic [FB_ADDR_W-1:0] Mem_Write_Add;
  logic [FB_DATA_W-1:0] Mem_Write_Data;

  modport master (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output Mem_Write, Mem_Write_Add, Mem_Write_Data
  );

  modport slave (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  Mem_Write, Mem_Write_Add, Mem_Write_Data
  );

endinterface

// File: rtl/cam_fb_writer_cdc_sync_edge.sv
// Two-flop synchroniser for a single asynchronous bit, with one extra stage for edge detect.
module cam_fb_writer_cdc_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic s1_q;
  logic s2_q;
  logic edge_q;

  // Synchroniser chain and previous-value register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      edge_q <= s2_q;
    end
  end

  assign lvl_o    = s2_q;
  assign rise_c_o = s2_q & ~edge_q;
  assign fall_c_o = ~s2_q & edge_q;

endmodule

// File: rtl/cam_fb_writer.sv
// Captures a parallel RGB565 camera stream into the clk domain and writes RGB444 pixels
// into the frame buffer, with per-frame line/error status.
module cam_fb_writer #(
  parameter int unsigned H_ACTIVE = cam_fb_writer_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = cam_fb_writer_pkg::V_ACTIVE
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              enable,
  cam_fb_writer_if.master                   bus,
  output logic                              frame_done,
  output logic [cam_fb_writer_pkg::CNT_W-1:0] frame_count,
  output logic [cam_fb_writer_pkg::CNT_W-1:0] line_count,
  output logic                              err_line,
  output logic                              err_overflow
);
  import cam_fb_writer_pkg::*;

  localparam int unsigned PIXELS = H_ACTIVE * V_ACTIVE;

  logic pclk_rise;
  logic pclk_lvl_unused;
  logic pclk_fall_unused;
  logic vsync_lvl;
  logic vsync_rise;
  logic vsync_fall;
  logic href_lvl;
  logic href_rise_unused;
  logic href_fall;

  logic [CAM_W-1:0] data_s1_q;
  logic [CAM_W-1:0] data_s2_q;

  logic pix_c;
  logic line_end_c;

  state_e               state_q,      state_d;
  logic                 phase_q,      phase_d;
  logic [CAM_W-1:0]     b0_q,         b0_d;
  logic [FB_ADDR_W-1:0] addr_q,       addr_d;
  logic [CNT_W-1:0]     lpix_q,       lpix_d;
  logic [CNT_W-1:0]     line_cnt_q,   line_cnt_d;
  logic [CNT_W-1:0]     frame_cnt_q,  frame_cnt_d;
  logic                 err_line_q,   err_line_d;
  logic                 err_ovf_q,    err_ovf_d;
  logic                 frame_done_q, frame_done_d;
  logic                 wr_en_q,      wr_en_d;
  fb_wr_t               wr_q,         wr_d;

  cam_fb_writer_cdc_sync_edge u_sync_pclk (
    .clk      (clk),
    .rstn     (rstn),
    .d_i      (bus.cam_pclk),
    .lvl_o    (pclk_lvl_unused),
    .rise_c_o (pclk_rise),
    .fall_c_o (pclk_fall_unused)
  );

  cam_fb_writer_cdc_sync_edge u_sync_vsync (
    .clk      (clk),
    .rstn     (rstn),
    .d_i      (bus.cam_vsync),
    .lvl_o    (vsync_lvl),
    .rise_c_o (vsync_rise),
    .fall_c_o (vsync_fall)
  );

  cam_fb_writer_cdc_sync_edge u_sync_href (
    .clk      (clk),
    .rstn     (rstn),
    .d_i      (bus.cam_href),
    .lvl_o    (href_lvl),
    .rise_c_o (href_rise_unused),
    .fall_c_o (href_fall)
  );

  // Camera byte bus: plain two-flop stage aligned with the href/pclk synchronisers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      data_s1_q <= bus.cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  // A byte is valid on a pclk rise inside a line and outside vertical blanking; a line
  // end that coincides with the vsync rise still counts so it lands before frame_done.
  assign pix_c      = pclk_rise & href_lvl & ~vsync_lvl;
  assign line_end_c = href_fall & (~vsync_lvl | vsync_rise);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      b0_q         <= '0;
      addr_q       <= '0;
      lpix_q       <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      err_line_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_q         <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      b0_q         <= b0_d;
      addr_q       <= addr_d;
      lpix_q       <= lpix_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      err_line_q   <= err_line_d;
      err_ovf_q    <= err_ovf_d;
      frame_done_q <= frame_done_d;
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
    end
  end

  // Capture FSM: next state, pixel assembly, line/frame accounting.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    b0_d         = b0_q;
    addr_d       = addr_q;
    lpix_d       = lpix_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    err_line_d   = err_line_q;
    err_ovf_d    = err_ovf_q;
    frame_done_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_d         = wr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_VS;
      end

      ST_WAIT_VS: begin
        if (!enable)        state_d = ST_IDLE;
        else if (vsync_lvl) state_d = ST_ARMED;
      end

      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (vsync_fall) begin
          state_d    = ST_ACTIVE;
          phase_d    = 1'b0;
          addr_d     = '0;
          lpix_d     = '0;
          line_cnt_d = '0;
          err_line_d = 1'b0;
          err_ovf_d  = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (pix_c) begin
          if (!phase_q) begin
            b0_d    = data_s2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (lpix_q != '1) lpix_d = lpix_q + CNT_W'(1);
            if (addr_q < FB_ADDR_W'(PIXELS)) begin
              wr_en_d   = 1'b1;
              wr_d.addr = addr_q;
              wr_d.data = rgb565_to_444({b0_q, data_s2_q});
              addr_d    = addr_q + FB_ADDR_W'(1);
            end else begin
              err_ovf_d = 1'b1;
            end
          end
        end

        if (line_end_c) begin
          line_cnt_d = line_cnt_q + CNT_W'(1);
          if (phase_q || (lpix_q != CNT_W'(H_ACTIVE))) err_line_d = 1'b1;
          phase_d = 1'b0;
          lpix_d  = '0;
        end

        // End of frame; a dangling half pixel is discarded and flagged.
        if (vsync_rise) begin
          if (phase_q) err_line_d = 1'b1;
          phase_d      = 1'b0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          state_d      = enable ? ST_ARMED : ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Mem_Write      = wr_en_q;
  assign bus.Mem_Write_Add  = wr_q.addr;
  assign bus.Mem_Write_Data = wr_q.data;
  assign frame_done         = frame_done_q;
  assign frame_count        = frame_cnt_q;
  assign line_count         = line_cnt_q;
  assign err_line           = err_line_q;
  assign err_overflow       = err_ovf_q;

endmodule
